// File: rtl/calc_resp_pkg.sv
// calc_resp_pkg: shared definitions for the calculator response collector.
//   - CALC_DATA_WIDTH : response data width of the calculator DUT
//   - NUM_PORTS       : number of calculator response ports
//   - CALC_RESP_*     : 2-bit response codes
//   - calc_resp_entry_t : one queued response {port, tag, resp, data}
//   - rr_next()       : round-robin successor of a port index
package calc_resp_pkg;

  localparam int CALC_DATA_WIDTH = 32;
  localparam int NUM_PORTS       = 4;

  localparam logic [1:0] CALC_RESP_IDLE = 2'b00;
  localparam logic [1:0] CALC_RESP_OK   = 2'b01;
  localparam logic [1:0] CALC_RESP_OVF  = 2'b10;
  localparam logic [1:0] CALC_RESP_INV  = 2'b11;

  typedef struct packed {
    logic [1:0]                 port;
    logic [1:0]                 tag;
    logic [1:0]                 resp;
    logic [CALC_DATA_WIDTH-1:0] data;
  } calc_resp_entry_t;

  // Port indices are 2 bits wide, so the increment wraps 3 -> 0 naturally.
  function automatic logic [1:0] rr_next(input logic [1:0] w);
    return w + 2'd1;
  endfunction

endpackage

// File: rtl/calc_resp_fifo.sv
// calc_resp_fifo: synchronous first-word-fall-through FIFO of calc_resp_entry_t.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (pointers and count only)
//   push  : write din this cycle; caller guarantees space (or a same-cycle pop)
//   din   : entry to write
//   pop   : retire head this cycle; caller guarantees count != 0
//   dout  : head entry (valid whenever count != 0)
//   count : occupancy, 0..DEPTH
// DEPTH must be a power of two >= 2 so pointers wrap by plain overflow.
module calc_resp_fifo
  import calc_resp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  calc_resp_entry_t         din,
  input  logic                     pop,
  output calc_resp_entry_t         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  calc_resp_entry_t r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;

  // Storage is not reset; the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop)  r_rd <= r_rd + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd];
  assign count = r_count;

endmodule

// File: rtl/calc_resp_collector.sv
// calc_resp_collector: gathers responses from the four calculator ports into
// one valid/ready stream tagged with the originating port.
//   PClk, Rst            : clock, synchronous active-high reset
//   out_respN/dataN/tagN : calculator port N response (resp 00 = idle)
//   col_valid/col_ready  : output handshake (FWFT head)
//   col_port/tag/resp/data : head entry, port 0..3 = calculator port 1..4
//   col_count            : FIFO occupancy
//   overrun/clr_overrun  : sticky per-port drop flags and their clear
// Optional: define CALC_RESP_STATS_EN to add saturating per-port ok_cnt and
// err_cnt counters of accepted captures (cleared by Rst and clr_overrun).
module calc_resp_collector
  import calc_resp_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = CALC_DATA_WIDTH
) (
  input  logic                          PClk,
  input  logic                          Rst,
  input  logic [1:0]                    out_resp1,
  input  logic [1:0]                    out_resp2,
  input  logic [1:0]                    out_resp3,
  input  logic [1:0]                    out_resp4,
  input  logic [DATA_W-1:0]             out_data1,
  input  logic [DATA_W-1:0]             out_data2,
  input  logic [DATA_W-1:0]             out_data3,
  input  logic [DATA_W-1:0]             out_data4,
  input  logic [1:0]                    out_tag1,
  input  logic [1:0]                    out_tag2,
  input  logic [1:0]                    out_tag3,
  input  logic [1:0]                    out_tag4,
  output logic                          col_valid,
  input  logic                          col_ready,
  output logic [1:0]                    col_port,
  output logic [1:0]                    col_tag,
  output logic [1:0]                    col_resp,
  output logic [DATA_W-1:0]             col_data,
  output logic [$clog2(FIFO_DEPTH):0]   col_count,
  output logic [NUM_PORTS-1:0]          overrun,
  input  logic                          clr_overrun
`ifdef CALC_RESP_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]    ok_cnt,
  output logic [NUM_PORTS-1:0][15:0]    err_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NUM_PORTS-1:0][1:0]        w_in_resp;
  logic [NUM_PORTS-1:0][1:0]        w_in_tag;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_in_data;

  assign w_in_resp = {out_resp4, out_resp3, out_resp2, out_resp1};
  assign w_in_tag  = {out_tag4,  out_tag3,  out_tag2,  out_tag1};
  assign w_in_data = {out_data4, out_data3, out_data2, out_data1};

  // Holding registers, one per port.
  logic [NUM_PORTS-1:0]             r_hv;
  logic [NUM_PORTS-1:0][1:0]        r_h_tag;
  logic [NUM_PORTS-1:0][1:0]        r_h_resp;
  logic [NUM_PORTS-1:0][DATA_W-1:0] r_h_data;
  logic [1:0]                       r_rr;
  logic [NUM_PORTS-1:0]             r_ovr;

  logic [NUM_PORTS-1:0] w_cap;
  logic [NUM_PORTS-1:0] w_drop;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [1:0]           w_win;
  logic [1:0]           w_idx;
  logic                 w_any;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_push_ok;

  calc_resp_entry_t     w_din;
  calc_resp_entry_t     w_dout;
  logic [AW:0]          w_count;

  assign col_valid = (w_count != '0);
  assign w_pop     = col_valid & col_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = (w_count < (AW+1)'(FIFO_DEPTH)) | w_pop;

  // Round-robin: first valid holding register at or after r_rr.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = r_rr + 2'(k);
      if (!w_any && r_hv[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    w_push = w_any & w_push_ok;
    w_gnt  = w_push ? (NUM_PORTS'(1) << w_win) : '0;
  end

  always_comb begin
    w_din      = '0;
    w_din.port = w_win;
    w_din.tag  = r_h_tag[w_win];
    w_din.resp = r_h_resp[w_win];
    w_din.data = r_h_data[w_win];
  end

  // A holding register accepts a new response if empty or draining this cycle;
  // otherwise the new response is dropped and flagged.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_cap[p]  = (w_in_resp[p] != CALC_RESP_IDLE) && (!r_hv[p] || w_gnt[p]);
      w_drop[p] = (w_in_resp[p] != CALC_RESP_IDLE) && r_hv[p] && !w_gnt[p];
    end
  end

  always_ff @(posedge PClk) begin
    if (Rst) begin
      r_hv     <= '0;
      r_h_tag  <= '0;
      r_h_resp <= '0;
      r_h_data <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_cap[p]) begin
          r_hv[p]     <= 1'b1;
          r_h_tag[p]  <= w_in_tag[p];
          r_h_resp[p] <= w_in_resp[p];
          r_h_data[p] <= w_in_data[p];
        end else if (w_gnt[p]) begin
          r_hv[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge PClk) begin
    if (Rst) begin
      r_rr  <= '0;
      r_ovr <= '0;
    end else begin
      if (w_push) r_rr <= rr_next(w_win);
      // A new drop wins over a same-cycle clear, bit by bit.
      r_ovr <= (r_ovr & ~{NUM_PORTS{clr_overrun}}) | w_drop;
    end
  end

  calc_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (PClk),
    .rst   (Rst),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_dout),
    .count (w_count)
  );

  // Head fields are forced to zero while empty so nothing stale shows.
  assign col_port  = col_valid ? w_dout.port : '0;
  assign col_tag   = col_valid ? w_dout.tag  : '0;
  assign col_resp  = col_valid ? w_dout.resp : '0;
  assign col_data  = col_valid ? DATA_W'(w_dout.data) : '0;
  assign col_count = w_count;
  assign overrun   = r_ovr;

`ifdef CALC_RESP_STATS_EN
  logic [NUM_PORTS-1:0][15:0] r_ok_cnt;
  logic [NUM_PORTS-1:0][15:0] r_err_cnt;

  always_ff @(posedge PClk) begin
    if (Rst || clr_overrun) begin
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_cap[p]) begin
          if (w_in_resp[p] == CALC_RESP_OK) begin
            if (r_ok_cnt[p] != 16'hFFFF) r_ok_cnt[p] <= r_ok_cnt[p] + 16'd1;
          end else if (r_err_cnt[p] != 16'hFFFF) begin
            r_err_cnt[p] <= r_err_cnt[p] + 16'd1;
          end
        end
      end
    end
  end

  assign ok_cnt  = r_ok_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule
